// File: rtl/opcode_seq_pkg.sv
// Shared opcode, state and instruction-class definitions for the opcode sequencer.
package opcode_seq_pkg;

   localparam int SEL_W = 20;

   localparam logic [4:0] OP_ADD   = 5'd0;
   localparam logic [4:0] OP_SUB   = 5'd1;
   localparam logic [4:0] OP_LOAD  = 5'd2;
   localparam logic [4:0] OP_STORE = 5'd3;
   localparam logic [4:0] OP_SGE   = 5'd4;
   localparam logic [4:0] OP_SLE   = 5'd5;
   localparam logic [4:0] OP_SEQ   = 5'd6;
   localparam logic [4:0] OP_SLI   = 5'd7;
   localparam logic [4:0] OP_SRI   = 5'd8;
   localparam logic [4:0] OP_ADDI  = 5'd9;
   localparam logic [4:0] OP_SUBI  = 5'd10;
   localparam logic [4:0] OP_NOP   = 5'd11;
   localparam logic [4:0] OP_MOVE  = 5'd12;
   localparam logic [4:0] OP_MOVEI = 5'd13;
   localparam logic [4:0] OP_ADDF  = 5'd18;
   localparam logic [4:0] OP_MULF  = 5'd19;

   typedef enum logic [2:0] {
      IDLE,
      DECODE,
      EXEC,
      MEM,
      WB
   } state_t;

   typedef enum logic [2:0] {
      CLS_ALU,
      CLS_MEM_LD,
      CLS_MEM_ST,
      CLS_NOP,
      CLS_FP,
      CLS_ILLEGAL
   } cls_t;

endpackage

// File: rtl/opcode_seq_decode.sv
// Combinational opcode decoder: one-hot select, instruction class and legality.
// ADDF/MULF are legal only when OPCODE_SEQUENCER_FLOAT_EN is defined.
module opcode_seq_decode
   import opcode_seq_pkg::*;
(
   input  logic [4:0]       opcode,
   output logic [SEL_W-1:0] sel,
   output cls_t             cls,
   output logic             legal
);

   always_comb begin
      cls   = CLS_ILLEGAL;
      legal = 1'b0;
      case (opcode)
         OP_ADD, OP_SUB, OP_SGE, OP_SLE, OP_SEQ, OP_SLI, OP_SRI,
         OP_ADDI, OP_SUBI, OP_MOVE, OP_MOVEI: begin
            cls   = CLS_ALU;
            legal = 1'b1;
         end
         OP_LOAD: begin
            cls   = CLS_MEM_LD;
            legal = 1'b1;
         end
         OP_STORE: begin
            cls   = CLS_MEM_ST;
            legal = 1'b1;
         end
         OP_NOP: begin
            cls   = CLS_NOP;
            legal = 1'b1;
         end
`ifdef OPCODE_SEQUENCER_FLOAT_EN
         OP_ADDF, OP_MULF: begin
            cls   = CLS_FP;
            legal = 1'b1;
         end
`endif
         default: ;
      endcase
      // Opcode value doubles as the select bit index; illegal codes select nothing.
      sel = legal ? (SEL_W'(1) << opcode) : '0;
   end

endmodule

// File: rtl/opcode_sequencer.sv
// Multi-cycle IDLE/DECODE/EXEC/MEM/WB sequencer driving the one-hot operand select bus.
// Define OPCODE_SEQUENCER_FLOAT_EN to enable ADDF/MULF with FP_LAT EXEC cycles.
module opcode_sequencer
   import opcode_seq_pkg::*;
#(
   parameter int FP_LAT = 3,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic [4:0]       opcode,
   input  logic             mem_ready,
   output logic [SEL_W-1:0] select,
   output logic             rf_we,
   output logic             mem_re,
   output logic             mem_we,
   output logic             done,
   output logic             illegal,
   output logic [CNT_W-1:0] retired
);

   if (FP_LAT < 1 || FP_LAT > 15) begin : g_bad_fp_lat
      $error("FP_LAT must be in 1..15");
   end

   state_t           state_q, state_d;
   cls_t             cls_q;
   logic [SEL_W-1:0] select_q;
   logic [CNT_W-1:0] retired_q;
   logic [SEL_W-1:0] dec_sel;
   cls_t             dec_cls;
   logic             dec_legal;
   logic             accept;
   logic             fp_busy;

   opcode_seq_decode u_decode (
      .opcode (opcode),
      .sel    (dec_sel),
      .cls    (dec_cls),
      .legal  (dec_legal)
   );

   assign accept = instr_valid && (state_q == IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cls_q     <= CLS_NOP;
         select_q  <= '0;
         retired_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            cls_q    <= dec_cls;
            select_q <= dec_sel;
         end else if (state_d == IDLE) begin
            select_q <= '0;
         end
         // Count on entry to WB so the new total is visible alongside done.
         if (state_d == WB) begin
            retired_q <= retired_q + CNT_W'(1);
         end
      end
   end

`ifdef OPCODE_SEQUENCER_FLOAT_EN
   localparam logic [3:0] FP_LOAD = 4'(FP_LAT - 1);
   logic [3:0] fp_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fp_cnt_q <= 4'd0;
      end else if (state_q == DECODE) begin
         fp_cnt_q <= FP_LOAD;
      end else if (state_q == EXEC && fp_cnt_q != 4'd0) begin
         fp_cnt_q <= fp_cnt_q - 4'd1;
      end
   end

   assign fp_busy = (cls_q == CLS_FP) && (fp_cnt_q != 4'd0);
`else
   assign fp_busy = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      instr_ready = 1'b0;
      done        = 1'b0;
      illegal     = 1'b0;
      rf_we       = 1'b0;
      mem_re      = 1'b0;
      mem_we      = 1'b0;
      case (state_q)
         IDLE: begin
            instr_ready = 1'b1;
            if (instr_valid) state_d = DECODE;
         end
         DECODE: begin
            case (cls_q)
               CLS_ILLEGAL: begin
                  illegal = 1'b1;
                  state_d = IDLE;
               end
               CLS_NOP: state_d = WB;
               default: state_d = EXEC;
            endcase
         end
         EXEC: begin
            if (!fp_busy) begin
               state_d = (cls_q == CLS_MEM_LD || cls_q == CLS_MEM_ST) ? MEM : WB;
            end
         end
         MEM: begin
            mem_re = (cls_q == CLS_MEM_LD);
            mem_we = (cls_q == CLS_MEM_ST);
            if (mem_ready) state_d = WB;
         end
         WB: begin
            done    = 1'b1;
            rf_we   = (cls_q != CLS_MEM_ST) && (cls_q != CLS_NOP);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign select  = select_q;
   assign retired = retired_q;

endmodule
